// File: rtl/bitwise_unit_arbiter.sv
// Round-robin arbiter sharing one N-bit AND/OR/XOR/XNOR unit between R requesters.
// The winning result is registered into a single-entry buffer tagged with the requester ID.
module bitwise_unit_arbiter #(
  parameter int N = 8,
  parameter int R = 4,
  localparam int IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  input  logic [2*R-1:0] req_op,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [N-1:0]   rsp_data,
  output logic [IDW-1:0] rsp_id,
  output logic [15:0]    op_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_r, next_state_s;
  logic [N-1:0]   rsp_data_r;
  logic [IDW-1:0] rsp_id_r;
  logic [IDW-1:0] last_grant_r;
  logic [15:0]    op_count_r;

  logic           grant_found_s;
  logic [IDW-1:0] grant_idx_s;
  logic           can_accept_s;
  logic           accept_s;
  logic           drain_s;
  logic [N-1:0]   result_s;

  function automatic logic [N-1:0] op_result(input logic [1:0] op,
                                             input logic [N-1:0] a,
                                             input logic [N-1:0] b);
    logic [N-1:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      2'b11:   r = ~(a ^ b);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int cand;
    cand          = 0;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = 0; k < R; k++) begin
      cand = (int'(last_grant_r) + 1 + k) % R;
      if (!grant_found_s && req_valid[cand]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = IDW'(cand);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  assign rsp_valid    = (state_r == FULL);
  assign can_accept_s = !rsp_valid || rsp_ready;
  assign accept_s     = grant_found_s && can_accept_s;
  assign drain_s      = rsp_valid && rsp_ready;
  assign req_ready    = accept_s ? ({{(R-1){1'b0}}, 1'b1} << grant_idx_s) : {R{1'b0}};
  assign result_s     = op_result(req_op[2*int'(grant_idx_s) +: 2],
                                  req_a[N*int'(grant_idx_s) +: N],
                                  req_b[N*int'(grant_idx_s) +: N]);

  // Buffer occupancy: a drain with a same-cycle accept keeps the buffer full.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) next_state_s = FULL;
        else          next_state_s = EMPTY;
      end
      FULL: begin
        if (accept_s)     next_state_s = FULL;
        else if (drain_s) next_state_s = EMPTY;
        else              next_state_s = FULL;
      end
      default: next_state_s = EMPTY;
    endcase
  end

  // Result buffer, round-robin pointer and response counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= EMPTY;
      rsp_data_r   <= '0;
      rsp_id_r     <= '0;
      last_grant_r <= IDW'(R - 1);
      op_count_r   <= 16'h0000;
    end else begin
      state_r <= next_state_s;
      if (accept_s) begin
        rsp_data_r   <= result_s;
        rsp_id_r     <= grant_idx_s;
        last_grant_r <= grant_idx_s;
      end
      if (drain_s) begin
        op_count_r <= op_count_r + 16'h0001;
      end
    end
  end

  assign rsp_data = rsp_data_r;
  assign rsp_id   = rsp_id_r;
  assign op_count = op_count_r;

endmodule

// File: tb/tb_bitwise_unit_arbiter.sv
// Directed bench for bitwise_unit_arbiter (N=8, R=4) with hand-computed expectations.
module tb_bitwise_unit_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic [15:0] op_count;

  int compared   = 0;
  int mismatched = 0;

  bitwise_unit_arbiter #(.N(8), .R(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    req_a[i*8 +: 8]  = a;
    req_b[i*8 +: 8]  = b;
    req_op[i*2 +: 2] = op;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [7:0] sweep_exp [4];
  logic [7:0] fair_exp  [4];

  initial begin
    sweep_exp[0] = 8'h30; sweep_exp[1] = 8'hFC; sweep_exp[2] = 8'hCC; sweep_exp[3] = 8'h33;
    fair_exp[0]  = 8'h30; fair_exp[1]  = 8'hFC; fair_exp[2]  = 8'hCC; fair_exp[3]  = 8'h33;
    req_valid = 4'b0000; req_a = 32'h0; req_b = 32'h0; req_op = 8'h0; rsp_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data",  32'(rsp_data),  32'h0);
    check("rst_rsp_id",    32'(rsp_id),    32'h0);
    check("rst_op_count",  32'(op_count),  32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    rst = 1'b0;

    // Single XNOR request from requester 2
    set_req(2, 8'hA5, 8'h0F, 2'b11);
    req_valid = 4'b0100; rsp_ready = 1'b1;
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    check("single_valid", 32'(rsp_valid), 32'h1);
    check("single_data",  32'(rsp_data),  32'h55);
    check("single_id",    32'(rsp_id),    32'h2);
    check("single_cnt0",  32'(op_count),  32'h0);
    tick();
    check("single_cnt1",  32'(op_count),  32'h1);
    check("single_drain", 32'(rsp_valid), 32'h0);
    check("single_hold",  32'(rsp_data),  32'h55);

    // Back-to-back opcode sweep on requester 0
    req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 8'hF0, 8'h3C, 2'(k));
      #1;
      check($sformatf("sweep_ready%0d", k), 32'(req_ready), 32'h1);
      tick();
      check($sformatf("sweep_valid%0d", k), 32'(rsp_valid), 32'h1);
      check($sformatf("sweep_data%0d", k),  32'(rsp_data),  32'(sweep_exp[k]));
      check($sformatf("sweep_id%0d", k),    32'(rsp_id),    32'h0);
    end
    req_valid = 4'b0000;
    tick();
    check("sweep_empty", 32'(rsp_valid), 32'h0);
    check("sweep_cnt",   32'(op_count),  32'h5);

    // Fairness: all four requesters continuously valid
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 8'hF0, 8'h3C, 2'(i));
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("fair_id%0d", k),   32'(rsp_id),   32'(k % 4));
      check($sformatf("fair_data%0d", k), 32'(rsp_data), 32'(fair_exp[k % 4]));
    end
    req_valid = 4'b0000;
    tick();
    check("fair_cnt",   32'(op_count),  32'h8);
    check("fair_empty", 32'(rsp_valid), 32'h0);

    // Backpressure with requesters 1 and 3 waiting
    rsp_ready = 1'b0;
    set_req(0, 8'hFF, 8'h0F, 2'b00);
    req_valid = 4'b0001;
    #1;
    check("bp_load_ready", 32'(req_ready), 32'h1);
    tick();
    set_req(1, 8'hAA, 8'h55, 2'b01);
    set_req(3, 8'hAA, 8'h0F, 2'b10);
    req_valid = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_ready%0d", k), 32'(req_ready), 32'h0);
      check($sformatf("bp_data%0d", k),  32'(rsp_data),  32'h0F);
      check($sformatf("bp_id%0d", k),    32'(rsp_id),    32'h0);
      check($sformatf("bp_valid%0d", k), 32'(rsp_valid), 32'h1);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'h2);
    tick();
    check("bp_swap_valid", 32'(rsp_valid), 32'h1);
    check("bp_swap_data",  32'(rsp_data),  32'hFF);
    check("bp_swap_id",    32'(rsp_id),    32'h1);
    check("bp_swap_cnt",   32'(op_count),  32'h9);
    req_valid = 4'b1000;
    #1;
    check("bp_r3_ready", 32'(req_ready), 32'h8);
    tick();
    check("bp_r3_data", 32'(rsp_data), 32'hA5);
    check("bp_r3_id",   32'(rsp_id),   32'h3);
    req_valid = 4'b0000;
    tick();
    check("bp_cnt", 32'(op_count), 32'hB);

    // Pointer skip: move pointer to 1, then wrap to 0, then 3 before 0
    set_req(1, 8'h0F, 8'hF0, 2'b10);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    tick();
    set_req(0, 8'h12, 8'h34, 2'b00);
    set_req(3, 8'h12, 8'h34, 2'b01);
    req_valid = 4'b0001;
    #1;
    check("skip_wrap_ready", 32'(req_ready), 32'h1);
    tick();
    check("skip_wrap_id",   32'(rsp_id),   32'h0);
    check("skip_wrap_data", 32'(rsp_data), 32'h10);
    req_valid = 4'b1001;
    #1;
    check("skip_r3_ready", 32'(req_ready), 32'h8);
    tick();
    check("skip_r3_id",   32'(rsp_id),   32'h3);
    check("skip_r3_data", 32'(rsp_data), 32'h36);
    req_valid = 4'b0000;
    tick();
    check("skip_cnt", 32'(op_count), 32'hE);

    // Asynchronous reset while a result is stalled
    rsp_ready = 1'b0;
    set_req(2, 8'hC3, 8'h3C, 2'b01);
    req_valid = 4'b0100;
    tick();
    check("mid_loaded", 32'(rsp_valid), 32'h1);
    req_valid = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_cnt",   32'(op_count),  32'h0);
    check("mid_rst_data",  32'(rsp_data),  32'h0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("mid_prio_ready", 32'(req_ready), 32'h1);
    tick();
    check("mid_prio_id", 32'(rsp_id), 32'h0);
    req_valid = 4'b0000;

    // op_count wrap over 65536 responses
    do_reset();
    set_req(0, 8'h01, 8'h01, 2'b00);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    repeat (65536) tick();
    check("wrap_ffff", 32'(op_count), 32'hFFFF);
    req_valid = 4'b0000;
    tick();
    check("wrap_zero",  32'(op_count),  32'h0);
    check("wrap_empty", 32'(rsp_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
